// File: rtl/dcmac_reset_sequencer.sv
// Reset bring-up sequencer for one DCMAC 100GbE port and its GT Quad.
// Drives the DCMAC helper user_* resets from synchronized GT and alignment status.
module dcmac_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned DONE_TIMEOUT  = 1048576,
    parameter int unsigned ALIGN_TIMEOUT = 4194304,
    parameter logic [3:0]  LANE_MASK     = 4'b1111,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned SYNC_STAGES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       gtpowergood,
    input  logic [3:0] gt_tx_reset_done,
    input  logic [3:0] gt_rx_reset_done,
    input  logic       rx_aligned,
    output logic       user_gt_reset_all,
    output logic       user_gt_reset_tx_datapath,
    output logic       user_gt_reset_rx_datapath,
    output logic       user_tx_serdes_reset,
    output logic       user_rx_serdes_reset,
    output logic       user_tx_core_reset,
    output logic       user_rx_core_reset,
    output logic       link_up,
    output logic       busy,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_A   = (DONE_TIMEOUT > ALIGN_TIMEOUT) ? DONE_TIMEOUT : ALIGN_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_PWR     = 3'd0,
        S_GT_RST  = 3'd1,
        S_GT_WAIT = 3'd2,
        S_SERDES  = 3'd3,
        S_CORE    = 3'd4,
        S_ALIGN   = 3'd5,
        S_UP      = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    state_t                        cur, nxt;
    logic [CW-1:0]                 cnt, cnt_n;
    logic [3:0]                    retry_n;
    logic [6:0]                    rst_vec, rst_vec_n;
    logic [SYNC_STAGES-1:0]        pg_sync, al_sync;
    logic [SYNC_STAGES-1:0][3:0]   tx_sync, rx_sync;
    logic                          pg_s, al_s, gt_done, timed, entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pg_sync <= '0;
            al_sync <= '0;
            tx_sync <= '0;
            rx_sync <= '0;
        end else begin
            pg_sync[0] <= gtpowergood;
            al_sync[0] <= rx_aligned;
            tx_sync[0] <= gt_tx_reset_done;
            rx_sync[0] <= gt_rx_reset_done;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                pg_sync[i] <= pg_sync[i-1];
                al_sync[i] <= al_sync[i-1];
                tx_sync[i] <= tx_sync[i-1];
                rx_sync[i] <= rx_sync[i-1];
            end
        end
    end

    assign pg_s    = pg_sync[SYNC_STAGES-1];
    assign al_s    = al_sync[SYNC_STAGES-1];
    assign gt_done = &((tx_sync[SYNC_STAGES-1] & rx_sync[SYNC_STAGES-1]) | ~LANE_MASK);

    always_comb begin
        nxt     = cur;
        retry_n = retry_count;
        // Timeout handling: saturating retry count, give up once MAX_RETRY retries are spent
        case (cur)
            S_PWR:     if (pg_s) nxt = S_GT_RST;
            S_GT_RST:  if (cnt == CW'(HOLD_CYCLES - 1)) nxt = S_GT_WAIT;
            S_GT_WAIT: begin
                if (gt_done) nxt = S_SERDES;
                else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
                    if (retry_count == 4'(MAX_RETRY)) nxt = S_FAIL;
                    else begin
                        nxt     = S_GT_RST;
                        retry_n = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
                    end
                end
            end
            S_SERDES:  if (cnt == CW'(HOLD_CYCLES - 1)) nxt = S_CORE;
            S_CORE:    if (cnt == CW'(HOLD_CYCLES - 1)) nxt = S_ALIGN;
            S_ALIGN: begin
                if (al_s) nxt = S_UP;
                else if (cnt == CW'(ALIGN_TIMEOUT - 1)) begin
                    if (retry_count == 4'(MAX_RETRY)) nxt = S_FAIL;
                    else begin
                        nxt     = S_GT_RST;
                        retry_n = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
                    end
                end
            end
            S_UP:      if (!al_s) nxt = S_CORE;
            default:   nxt = cur;
        endcase
        if (!pg_s && cur != S_PWR && cur != S_FAIL) begin
            nxt     = S_PWR;
            retry_n = retry_count;
        end
        if (restart) begin
            nxt     = S_GT_RST;
            retry_n = '0;
        end
        if (nxt == S_UP) retry_n = '0;
    end

    // Reset outputs are a pure function of the state being entered
    always_comb begin
        rst_vec_n = '1;
        case (nxt)
            S_GT_WAIT, S_SERDES: rst_vec_n = 7'b000_1111;
            S_CORE:              rst_vec_n = 7'b000_0011;
            S_ALIGN, S_UP:       rst_vec_n = '0;
            default:             rst_vec_n = '1;
        endcase
    end

    assign timed = (cur == S_GT_RST) || (cur == S_GT_WAIT) || (cur == S_SERDES) ||
                   (cur == S_CORE) || (cur == S_ALIGN);
    assign entry = (nxt != cur) || restart;

    always_comb begin
        cnt_n = cnt;
        if (entry || !timed) cnt_n = '0;
        else if (cnt != '1)  cnt_n = cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= S_PWR;
            cnt         <= '0;
            retry_count <= '0;
            rst_vec     <= '1;
            link_up     <= 1'b0;
            busy        <= 1'b1;
            fail        <= 1'b0;
        end else begin
            cur         <= nxt;
            cnt         <= cnt_n;
            retry_count <= retry_n;
            rst_vec     <= rst_vec_n;
            link_up     <= (nxt == S_UP);
            busy        <= (nxt != S_UP) && (nxt != S_FAIL);
            fail        <= (nxt == S_FAIL);
        end
    end

    assign state = cur;
    assign {user_gt_reset_all, user_gt_reset_tx_datapath, user_gt_reset_rx_datapath,
            user_tx_serdes_reset, user_rx_serdes_reset,
            user_tx_core_reset, user_rx_core_reset} = rst_vec;

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// Directed bench for dcmac_reset_sequencer: three instances sharing stimulus
// (nominal masks/timeouts, single-lane mask, short done timeout).
module tb_dcmac_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset, restart, pg, al;
    logic [3:0] tx, rx;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    logic [6:0] rsts, rsts_m, rsts_t;
    logic       lu, bz, fl, lu_m, bz_m, fl_m, lu_t, bz_t, fl_t;
    logic [2:0] st, st_m, st_t;
    logic [3:0] rc, rc_m, rc_t;

    dcmac_reset_sequencer #(.HOLD_CYCLES(8), .DONE_TIMEOUT(128), .ALIGN_TIMEOUT(256),
                            .LANE_MASK(4'b1111), .MAX_RETRY(3), .SYNC_STAGES(3)) dut (
        .clk(clk), .reset(reset), .restart(restart), .gtpowergood(pg),
        .gt_tx_reset_done(tx), .gt_rx_reset_done(rx), .rx_aligned(al),
        .user_gt_reset_all(rsts[6]), .user_gt_reset_tx_datapath(rsts[5]),
        .user_gt_reset_rx_datapath(rsts[4]), .user_tx_serdes_reset(rsts[3]),
        .user_rx_serdes_reset(rsts[2]), .user_tx_core_reset(rsts[1]),
        .user_rx_core_reset(rsts[0]), .link_up(lu), .busy(bz), .fail(fl),
        .state(st), .retry_count(rc));

    dcmac_reset_sequencer #(.HOLD_CYCLES(8), .DONE_TIMEOUT(128), .ALIGN_TIMEOUT(256),
                            .LANE_MASK(4'b0001), .MAX_RETRY(3), .SYNC_STAGES(3)) dut_m (
        .clk(clk), .reset(reset), .restart(restart), .gtpowergood(pg),
        .gt_tx_reset_done(tx), .gt_rx_reset_done(rx), .rx_aligned(al),
        .user_gt_reset_all(rsts_m[6]), .user_gt_reset_tx_datapath(rsts_m[5]),
        .user_gt_reset_rx_datapath(rsts_m[4]), .user_tx_serdes_reset(rsts_m[3]),
        .user_rx_serdes_reset(rsts_m[2]), .user_tx_core_reset(rsts_m[1]),
        .user_rx_core_reset(rsts_m[0]), .link_up(lu_m), .busy(bz_m), .fail(fl_m),
        .state(st_m), .retry_count(rc_m));

    dcmac_reset_sequencer #(.HOLD_CYCLES(8), .DONE_TIMEOUT(32), .ALIGN_TIMEOUT(256),
                            .LANE_MASK(4'b1111), .MAX_RETRY(3), .SYNC_STAGES(3)) dut_t (
        .clk(clk), .reset(reset), .restart(restart), .gtpowergood(pg),
        .gt_tx_reset_done(tx), .gt_rx_reset_done(rx), .rx_aligned(al),
        .user_gt_reset_all(rsts_t[6]), .user_gt_reset_tx_datapath(rsts_t[5]),
        .user_gt_reset_rx_datapath(rsts_t[4]), .user_tx_serdes_reset(rsts_t[3]),
        .user_rx_serdes_reset(rsts_t[2]), .user_tx_core_reset(rsts_t[1]),
        .user_rx_core_reset(rsts_t[0]), .link_up(lu_t), .busy(bz_t), .fail(fl_t),
        .state(st_t), .retry_count(rc_t));

    function automatic logic [2:0] cur_state(input int sel);
        case (sel)
            1:       return st_m;
            2:       return st_t;
            default: return st;
        endcase
    endfunction

    // Returns cycles until the selected instance shows state s, or -1 on budget expiry
    task automatic wait_state(input int sel, input logic [2:0] s, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (cur_state(sel) == s) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; restart = 1'b0; pg = 1'b0; al = 1'b0; tx = 4'h0; rx = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (st !== 3'd0)    begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
        checks++; if (rsts !== 7'h7F) begin failures++; $display("FAIL reset_rsts got=%h exp=7f", rsts); end
        checks++; if (lu !== 1'b0)    begin failures++; $display("FAIL reset_link_up got=%b exp=0", lu); end
        checks++; if (fl !== 1'b0)    begin failures++; $display("FAIL reset_fail got=%b exp=0", fl); end
        checks++; if (bz !== 1'b1)    begin failures++; $display("FAIL reset_busy got=%b exp=1", bz); end
        checks++; if (rc !== 4'd0)    begin failures++; $display("FAIL reset_retry got=%0d exp=0", rc); end
        repeat (5) @(posedge clk); #1;
        checks++; if (st !== 3'd0)    begin failures++; $display("FAIL pwr_hold got=%0d exp=0", st); end
    endtask

    task automatic test_nominal();
        int n;
        pg = 1'b1;
        wait_state(0, 3'd1, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL nom_enter_gtrst got=%0d exp=1", st); end
        checks++; if (rsts !== 7'h7F) begin failures++; $display("FAIL nom_gtrst_rsts got=%h exp=7f", rsts); end
        wait_state(0, 3'd2, 20, n);
        checks++; if (n != 8)         begin failures++; $display("FAIL nom_gtrst_hold got=%0d exp=8", n); end
        checks++; if (rsts !== 7'h0F) begin failures++; $display("FAIL nom_gtwait_rsts got=%h exp=0f", rsts); end
        repeat (80) @(posedge clk); #1;
        checks++; if (st !== 3'd2)    begin failures++; $display("FAIL nom_gtwait_stay got=%0d exp=2", st); end
        tx = 4'hF; rx = 4'hF;
        wait_state(0, 3'd3, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL nom_enter_serdes got=%0d exp=3", st); end
        wait_state(0, 3'd4, 20, n);
        checks++; if (n != 8)         begin failures++; $display("FAIL nom_serdes_hold got=%0d exp=8", n); end
        checks++; if (rsts !== 7'h03) begin failures++; $display("FAIL nom_core_rsts got=%h exp=03", rsts); end
        wait_state(0, 3'd5, 20, n);
        checks++; if (n != 8)         begin failures++; $display("FAIL nom_core_hold got=%0d exp=8", n); end
        checks++; if (rsts !== 7'h00) begin failures++; $display("FAIL nom_align_rsts got=%h exp=00", rsts); end
        repeat (50) @(posedge clk); #1;
        al = 1'b1;
        wait_state(0, 3'd6, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL nom_enter_up got=%0d exp=6", st); end
        checks++; if (lu !== 1'b1 || bz !== 1'b0 || fl !== 1'b0)
            begin failures++; $display("FAIL nom_up_flags got=%b%b%b exp=100", lu, bz, fl); end
        checks++; if (rc !== 4'd0)    begin failures++; $display("FAIL nom_up_retry got=%0d exp=0", rc); end
    endtask

    task automatic test_link_loss();
        int n;
        @(negedge clk) al = 1'b0;
        @(negedge clk) al = 1'b1;
        wait_state(0, 3'd4, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL ll_enter_core got=%0d exp=4", st); end
        checks++; if (rsts !== 7'h03) begin failures++; $display("FAIL ll_rsts got=%h exp=03", rsts); end
        checks++; if (lu !== 1'b0)    begin failures++; $display("FAIL ll_link_up got=%b exp=0", lu); end
        wait_state(0, 3'd5, 20, n);
        checks++; if (n != 8)         begin failures++; $display("FAIL ll_core_hold got=%0d exp=8", n); end
        wait_state(0, 3'd6, 5, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL ll_realign got=%0d exp=6", st); end
        checks++; if (rc !== 4'd0)    begin failures++; $display("FAIL ll_retry got=%0d exp=0", rc); end
    endtask

    task automatic test_pg_loss();
        int n;
        al = 1'b0;
        wait_state(0, 3'd5, 20, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL pg_enter_align got=%0d exp=5", st); end
        pg = 1'b0;
        wait_state(0, 3'd0, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL pg_enter_pwr got=%0d exp=0", st); end
        checks++; if (rsts !== 7'h7F || bz !== 1'b1)
            begin failures++; $display("FAIL pg_pwr_outputs got=%h/%b exp=7f/1", rsts, bz); end
        pg = 1'b1;
        wait_state(0, 3'd5, 60, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL pg_reenter_align got=%0d exp=5", st); end
        // pg falls now; its synchronized copy reaches the FSM on the 4th edge, together with restart
        @(negedge clk) pg = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        checks++; if (st !== 3'd1)    begin failures++; $display("FAIL collide_state got=%0d exp=1", st); end
        checks++; if (rsts !== 7'h7F) begin failures++; $display("FAIL collide_rsts got=%h exp=7f", rsts); end
        wait_state(0, 3'd0, 5, n);
        checks++; if (n != 1)         begin failures++; $display("FAIL collide_then_pwr got=%0d exp=1", n); end
    endtask

    task automatic test_lane_mask();
        int n;
        apply_reset();
        pg = 1'b1; tx = 4'b0001; rx = 4'b0000;
        wait_state(1, 3'd2, 20, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL lm_enter_wait got=%0d exp=2", st_m); end
        repeat (40) @(posedge clk); #1;
        checks++; if (st_m !== 3'd2)  begin failures++; $display("FAIL lm_rx0_low_stay got=%0d exp=2", st_m); end
        rx = 4'b0001;
        wait_state(1, 3'd3, 10, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL lm_pass got=%0d exp=3", st_m); end
        checks++; if (st !== 3'd2)    begin failures++; $display("FAIL lm_full_mask_stay got=%0d exp=2", st); end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        pg = 1'b1;
        wait_state(2, 3'd2, 20, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL to_enter_wait got=%0d exp=2", st_t); end
        for (int k = 1; k <= 3; k++) begin
            wait_state(2, 3'd1, 40, n);
            checks++; if (n != 32)    begin failures++; $display("FAIL to_interval_%0d got=%0d exp=32", k, n); end
            checks++; if (rc_t !== 4'(k)) begin failures++; $display("FAIL to_retry_%0d got=%0d exp=%0d", k, rc_t, k); end
            checks++; if (rsts_t !== 7'h7F) begin failures++; $display("FAIL to_rsts_%0d got=%h exp=7f", k, rsts_t); end
            wait_state(2, 3'd2, 20, n);
        end
        wait_state(2, 3'd7, 40, n);
        checks++; if (n != 32)        begin failures++; $display("FAIL to_fail_interval got=%0d exp=32", n); end
        checks++; if (fl_t !== 1'b1 || bz_t !== 1'b0 || rsts_t !== 7'h7F)
            begin failures++; $display("FAIL to_fail_outputs got=%b%b/%h exp=10/7f", fl_t, bz_t, rsts_t); end
        repeat (20) @(posedge clk); #1;
        checks++; if (st_t !== 3'd7 || rc_t !== 4'd3)
            begin failures++; $display("FAIL to_fail_sticky got=%0d/%0d exp=7/3", st_t, rc_t); end
        @(negedge clk) restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        checks++; if (st_t !== 3'd1 || rc_t !== 4'd0 || fl_t !== 1'b0)
            begin failures++; $display("FAIL to_restart got=%0d/%0d/%b exp=1/0/0", st_t, rc_t, fl_t); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        pg = 1'b1; tx = 4'hF; rx = 4'hF;
        wait_state(0, 3'd3, 40, n);
        checks++; if (n < 0)          begin failures++; $display("FAIL ar_enter_serdes got=%0d exp=3", st); end
        #2 reset = 1'b1;
        #1;
        checks++; if (st !== 3'd0 || rsts !== 7'h7F)
            begin failures++; $display("FAIL ar_state_rsts got=%0d/%h exp=0/7f", st, rsts); end
        checks++; if (lu !== 1'b0 || bz !== 1'b1 || fl !== 1'b0 || rc !== 4'd0)
            begin failures++; $display("FAIL ar_flags got=%b%b%b/%0d exp=010/0", lu, bz, fl, rc); end
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_link_loss();
        test_pg_loss();
        test_lane_mask();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
